sram_master: RTL and testbench

SRAM_MASTER -- requirements
Module: sram_master

---
 rtl/sram_master.sv | 157 +++++++++++++++
 tb/tb_sram_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_master.sv
// sram_master: pipelined request/response front end for a single-port synchronous SRAM.
// Requests are issued to the SRAM in the cycle they are accepted; responses
// (read data, write echo, misalignment error) return in order through a 2-deep queue.

// Two-entry response queue holding {rdata, we, err}.
module sram_master_rsp_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entries [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so no stale data is ever visible at the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    assign head_data = entries[rd_ptr];

endmodule

// Top level: request acceptance, SRAM drive, and response sequencing.
module sram_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_we_o,
    output logic                    rsp_err_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int ENTRY = DATA_WIDTH + 2;

    logic             misaligned;
    logic             accept;
    logic             pop;
    logic [1:0]       fifo_count;
    logic [1:0]       occ;
    logic             inflight;
    logic             inflight_we;
    logic             inflight_err;
    logic [DATA_WIDTH-1:0] push_rdata;
    logic [ENTRY-1:0] push_data;
    logic [ENTRY-1:0] head_data;

    // A word-wide bus with byte lanes needs the low offset bits clear; a byte-wide bus is always aligned.
    generate
        if (OFS > 0) begin : g_align
            assign misaligned = (req_addr_i[OFS-1:0] != '0);
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    // Occupancy counts queued responses plus the one whose SRAM data is still returning.
    assign occ = fifo_count + {1'b0, inflight};
    assign pop = rsp_valid_o && rsp_ready_i;

    // A slot freed by a pop this cycle can be reused immediately, keeping full throughput.
    assign req_ready_o = !rst && ((occ < 2'd2) || pop);
    assign accept      = req_valid_i && req_ready_o;

    // SRAM is driven straight from the request; misaligned requests never touch it.
    assign mem_en_o    = accept && !misaligned;
    assign mem_we_o    = req_we_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_be_o    = req_be_i;
    assign mem_wdata_o = req_wdata_i;

    // Remember what was accepted last cycle so its response can be formed when SRAM data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight     <= 1'b0;
            inflight_we  <= 1'b0;
            inflight_err <= 1'b0;
        end else begin
            inflight     <= accept;
            inflight_we  <= req_we_i;
            inflight_err <= misaligned;
        end
    end

    // Only aligned reads carry SRAM data; writes and errors return zero.
    assign push_rdata = (!inflight_we && !inflight_err) ? mem_rdata_i : '0;
    assign push_data  = {push_rdata, inflight_we, inflight_err};

    sram_master_rsp_fifo #(
        .WIDTH (ENTRY)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign rsp_valid_o = (fifo_count != 2'd0);
    assign rsp_rdata_o = head_data[ENTRY-1:2];
    assign rsp_we_o    = head_data[1];
    assign rsp_err_o   = head_data[0];

endmodule

// File: tb/tb_sram_master.sv
// tb_sram_master: directed self-checking bench for sram_master with a behavioural SRAM.
module tb_sram_master;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_addr_i;
    logic        req_we_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_we_o;
    logic        rsp_err_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] ram [64];

    int checks = 0;
    int errors = 0;

    sram_master #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_be_i    (req_be_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_we_o    (rsp_we_o),
        .rsp_err_o   (rsp_err_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: byte-masked writes, registered read data.
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) begin
                        ram[mem_addr_o[7:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
                    end
                end
            end else begin
                mem_rdata_i <= ram[mem_addr_o[7:2]];
            end
        end
    end

    // Guard against a runaway simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] addr, input logic we,
                                 input logic [3:0] be, input logic [31:0] wdata);
        req_valid_i = valid;
        req_addr_i  = addr;
        req_we_i    = we;
        req_be_i    = be;
        req_wdata_i = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("[TB] check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] <= 32'h5A00_0000 + 32'(i);
        end
        ram[0] <= 32'hCAFE_0000;
        ram[1] <= 32'hDEAD_BEEF;
        ram[2] <= 32'h0000_0000;
        mem_rdata_i <= 32'h0;

        // Reset: a pending request must not be accepted or reach the SRAM.
        rst         = 1'b1;
        rsp_ready_i = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        #1;
        checkOutput("rst_req_ready", req_ready_o, 0);
        checkOutput("rst_mem_en", mem_en_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("post_rst_ready", req_ready_o, 1);

        // Aligned read of word 1.
        tick();
        applyStimulus(1'b1, 8'h04, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("rd_mem_en", mem_en_o, 1);
        checkOutput("rd_mem_we", mem_we_o, 0);
        checkOutput("rd_mem_addr", mem_addr_o, 8'h04);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("rd_t1_valid", rsp_valid_o, 0);
        tick();
        #1;
        checkOutput("rd_t2_valid", rsp_valid_o, 1);
        checkOutput("rd_t2_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        checkOutput("rd_t2_err", rsp_err_o, 0);
        checkOutput("rd_t2_we", rsp_we_o, 0);
        tick();
        #1;
        checkOutput("rd_t3_valid", rsp_valid_o, 0);

        // Byte-masked write to word 2 followed by a read-back.
        tick();
        applyStimulus(1'b1, 8'h08, 1'b1, 4'b0101, 32'h1122_3344);
        #1;
        checkOutput("wr_mem_en", mem_en_o, 1);
        checkOutput("wr_mem_we", mem_we_o, 1);
        checkOutput("wr_mem_be", mem_be_o, 4'b0101);
        checkOutput("wr_mem_wdata", mem_wdata_o, 32'h1122_3344);
        tick();
        applyStimulus(1'b1, 8'h08, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("wrrd_mem_en", mem_en_o, 1);
        checkOutput("wrrd_mem_we", mem_we_o, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("wr_rsp_valid", rsp_valid_o, 1);
        checkOutput("wr_rsp_we", rsp_we_o, 1);
        checkOutput("wr_rsp_err", rsp_err_o, 0);
        checkOutput("wr_rsp_rdata", rsp_rdata_o, 32'h0);
        tick();
        #1;
        checkOutput("wrrd_rsp_valid", rsp_valid_o, 1);
        checkOutput("wrrd_rsp_we", rsp_we_o, 0);
        checkOutput("wrrd_rsp_rdata", rsp_rdata_o, 32'h0022_0044);
        tick();
        #1;
        checkOutput("wrrd_idle", rsp_valid_o, 0);

        // Misaligned read: no SRAM access, error response with zero data.
        tick();
        applyStimulus(1'b1, 8'h05, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mis_ready", req_ready_o, 1);
        checkOutput("mis_mem_en", mem_en_o, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mis_t1_valid", rsp_valid_o, 0);
        tick();
        #1;
        checkOutput("mis_valid", rsp_valid_o, 1);
        checkOutput("mis_err", rsp_err_o, 1);
        checkOutput("mis_rdata", rsp_rdata_o, 32'h0);
        tick();
        #1;
        checkOutput("mis_idle", rsp_valid_o, 0);

        // Write with no byte enables still goes to the SRAM and returns a clean write response.
        tick();
        applyStimulus(1'b1, 8'h40, 1'b1, 4'h0, 32'hFFFF_FFFF);
        #1;
        checkOutput("be0_mem_en", mem_en_o, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        tick();
        #1;
        checkOutput("be0_valid", rsp_valid_o, 1);
        checkOutput("be0_we", rsp_we_o, 1);
        checkOutput("be0_err", rsp_err_o, 0);
        checkOutput("be0_rdata", rsp_rdata_o, 32'h0);
        tick();
        #1;
        checkOutput("be0_idle", rsp_valid_o, 0);

        // Backpressure: two requests fill the pipeline, the third waits for the first pop.
        tick();
        rsp_ready_i = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("bp_ready_a", req_ready_o, 1);
        tick();
        applyStimulus(1'b1, 8'h04, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("bp_ready_b", req_ready_o, 1);
        tick();
        applyStimulus(1'b1, 8'h08, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("bp_ready_c", req_ready_o, 0);
        checkOutput("bp_mem_en_c", mem_en_o, 0);
        checkOutput("bp_head_valid", rsp_valid_o, 1);
        checkOutput("bp_head_rdata", rsp_rdata_o, 32'hCAFE_0000);
        tick();
        #1;
        checkOutput("bp_hold_ready", req_ready_o, 0);
        checkOutput("bp_hold_rdata", rsp_rdata_o, 32'hCAFE_0000);
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("bp_pop_ready", req_ready_o, 1);
        checkOutput("bp_pop_mem_en", mem_en_o, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("bp_second_valid", rsp_valid_o, 1);
        checkOutput("bp_second_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        tick();
        #1;
        checkOutput("bp_third_valid", rsp_valid_o, 1);
        checkOutput("bp_third_rdata", rsp_rdata_o, 32'h0022_0044);
        tick();
        #1;
        checkOutput("bp_idle", rsp_valid_o, 0);

        // Streaming: 16 reads of words 3..18, one response per cycle.
        for (int k = 0; k < 18; k++) begin
            tick();
            if (k < 16) begin
                applyStimulus(1'b1, 8'((3 + k) * 4), 1'b0, 4'h0, 32'h0);
            end else begin
                applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
            end
            #1;
            if (k < 16) begin
                checkOutput("stream_ready", req_ready_o, 1);
            end
            if (k >= 2) begin
                checkOutput("stream_valid", rsp_valid_o, 1);
                checkOutput("stream_rdata", rsp_rdata_o, 32'h5A00_0000 + 32'(k + 1));
            end
        end
        tick();
        #1;
        checkOutput("stream_idle", rsp_valid_o, 0);

        // Reset mid-operation discards queued and in-flight responses.
        tick();
        rsp_ready_i = 1'b0;
        applyStimulus(1'b1, 8'h0C, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mid_mem_en_a", mem_en_o, 1);
        tick();
        applyStimulus(1'b1, 8'h10, 1'b0, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 8'h14, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mid_queued_valid", rsp_valid_o, 1);
        checkOutput("mid_rst_ready", req_ready_o, 0);
        checkOutput("mid_rst_mem_en", mem_en_o, 0);
        tick();
        rst = 1'b0;
        rsp_ready_i = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mid_flush_valid", rsp_valid_o, 0);
        checkOutput("mid_after_ready", req_ready_o, 1);
        tick();
        #1;
        checkOutput("mid_no_stale", rsp_valid_o, 0);
        tick();
        applyStimulus(1'b1, 8'h14, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mid_new_mem_en", mem_en_o, 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("mid_new_t1", rsp_valid_o, 0);
        tick();
        #1;
        checkOutput("mid_new_valid", rsp_valid_o, 1);
        checkOutput("mid_new_rdata", rsp_rdata_o, 32'h5A00_0005);
        checkOutput("mid_new_err", rsp_err_o, 0);
        tick();
        #1;
        checkOutput("mid_new_idle", rsp_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
